// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the architectural PC, requests instruction words
// over a req/ack memory handshake and hands {instr, pc} to decode through a
// two-entry buffer (output register plus skid register). Branch redirects from
// execute flush the buffer and steer fetch to the new target.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] rf_pc_out
);

    localparam logic [31:0] PC_INC = 32'(PC_STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DISCARD
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic        req_q;
    logic        outValid_q;
    logic [31:0] outInstr_q;
    logic [31:0] outPc_q;
    logic        skidValid_q;
    logic [31:0] skidInstr_q;
    logic [31:0] skidPc_q;

    logic        consume;
    logic        take;
    logic [1:0]  held;
    logic        spaceNow;
    logic        spaceAfterTake;
    logic [31:0] pcNext;

    // Decode handshake and buffer occupancy; "held" counts entries still occupied
    // once this cycle's consume has drained the output register.
    always_comb begin
        consume        = outValid_q & ~id_stall;
        take           = imem_ack & (state_q == S_REQ);
        held           = {1'b0, outValid_q} + {1'b0, skidValid_q} - {1'b0, consume};
        spaceNow       = (held < 2'd2);
        spaceAfterTake = (held == 2'd0);
        pcNext         = pc_q + PC_INC;
    end

    // Fetch FSM, PC and the output/skid buffer; redirects outrank acks, and an
    // ack seen in S_IDLE is a leftover from an abandoned request and is ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            req_q       <= 1'b0;
            outValid_q  <= 1'b0;
            outInstr_q  <= 32'h0;
            outPc_q     <= 32'h0;
            skidValid_q <= 1'b0;
            skidInstr_q <= 32'h0;
            skidPc_q    <= 32'h0;
        end else if (br_taken) begin
            pc_q        <= br_target;
            outValid_q  <= 1'b0;
            skidValid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    addr_q  <= br_target;
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                end
                S_REQ: begin
                    req_q <= 1'b1;
                    if (imem_ack) begin
                        addr_q <= br_target;
                    end else begin
                        state_q <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    req_q <= 1'b1;
                    if (imem_ack) begin
                        addr_q  <= br_target;
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end else begin
            if (consume) begin
                if (skidValid_q) begin
                    outInstr_q <= skidInstr_q;
                    outPc_q    <= skidPc_q;
                    outValid_q <= 1'b1;
                    if (take) begin
                        skidInstr_q <= imem_rdata;
                        skidPc_q    <= addr_q;
                    end else begin
                        skidValid_q <= 1'b0;
                    end
                end else if (take) begin
                    outInstr_q <= imem_rdata;
                    outPc_q    <= addr_q;
                    outValid_q <= 1'b1;
                end else begin
                    outValid_q <= 1'b0;
                end
            end else if (take) begin
                if (outValid_q) begin
                    skidInstr_q <= imem_rdata;
                    skidPc_q    <= addr_q;
                    skidValid_q <= 1'b1;
                end else begin
                    outInstr_q <= imem_rdata;
                    outPc_q    <= addr_q;
                    outValid_q <= 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (spaceNow) begin
                        addr_q  <= pc_q;
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        pc_q <= pcNext;
                        if (spaceAfterTake) begin
                            addr_q <= pcNext;
                        end else begin
                            state_q <= S_IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                S_DISCARD: begin
                    if (imem_ack) begin
                        addr_q  <= pc_q;
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign id_valid  = outValid_q;
    assign id_instr  = outInstr_q;
    assign id_pc     = outPc_q;
    assign rf_pc_out = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: a small instruction-memory model with a
// configurable wait count answers requests, and each scenario checks the
// decode-side and memory-side outputs against hand-computed values.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        br_taken;
    logic [31:0] br_target;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] rf_pc_out;

    int checkCount;
    int failCount;
    int memLatency;
    int memWait;
    int memMode;

    fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .br_taken  (br_taken),
        .br_target (br_target),
        .id_stall  (id_stall),
        .id_valid  (id_valid),
        .id_instr  (id_instr),
        .id_pc     (id_pc),
        .rf_pc_out (rf_pc_out)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so a stuck run still ends with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got running, want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Instruction word the memory returns for a given address.
    function automatic logic [31:0] memData(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    // Single comparison point: counts the check and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, lets the memory model decide this cycle's ack
    // (mode 0 normal, 1 silent, 2 forced stray ack), then steps past the edge.
    task automatic applyStimulus(input logic br, input logic [31:0] tgt, input logic stall);
        br_taken  = br;
        br_target = tgt;
        id_stall  = stall;
        if (memMode == 1) begin
            imem_ack = 1'b0;
        end else if (memMode == 2) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hBADB_AD00;
        end else if (imem_req) begin
            if (memWait >= memLatency) begin
                imem_ack   = 1'b1;
                imem_rdata = memData(imem_addr);
                memWait    = 0;
            end else begin
                imem_ack = 1'b0;
                memWait++;
            end
        end else begin
            imem_ack = 1'b0;
            memWait  = 0;
        end
        @(posedge clk);
        #1;
        br_taken = 1'b0;
        imem_ack = 1'b0;
    endtask

    // Holds reset low for two edges with the memory silent; caller releases it.
    task automatic applyReset();
        reset   = 1'b0;
        memMode = 1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        memMode = 0;
        memWait = 0;
    endtask

    // Runs free cycles until the request address reaches a target, bounded.
    task automatic waitForAddr(input logic [31:0] target, input string tag);
        int n;
        n = 0;
        while (imem_addr !== target && n < 20) begin
            applyStimulus(1'b0, 32'h0, 1'b0);
            n++;
        end
        checkOutput(tag, imem_addr, target);
    endtask

    // Scenario sequence: streaming, stall/skid, latency with redirect, redirect
    // on ack, reset with a stray ack, and PC wrap-around.
    initial begin
        checkCount = 0;
        failCount  = 0;
        memLatency = 0;
        memWait    = 0;
        memMode    = 0;
        reset      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        br_taken   = 1'b0;
        br_target  = 32'h0;
        id_stall   = 1'b0;

        // Reset state then zero-wait streaming
        applyReset();
        checkOutput("rst_req", {31'h0, imem_req}, 32'h0);
        checkOutput("rst_addr", imem_addr, 32'h0);
        checkOutput("rst_valid", {31'h0, id_valid}, 32'h0);
        checkOutput("rst_instr", id_instr, 32'h0);
        checkOutput("rst_idpc", id_pc, 32'h0);
        checkOutput("rst_rfpc", rf_pc_out, 32'h0);
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t1_req", {31'h0, imem_req}, 32'h1);
        checkOutput("t1_addr0", imem_addr, 32'h0);
        checkOutput("t1_valid0", {31'h0, id_valid}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b0);
            checkOutput("t1_valid", {31'h0, id_valid}, 32'h1);
            checkOutput("t1_idpc", id_pc, 32'(4 * k));
            checkOutput("t1_instr", id_instr, memData(32'(4 * k)));
            checkOutput("t1_addr", imem_addr, 32'(4 * k + 4));
        end

        // Stall for three cycles with ack every cycle
        applyReset();
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t2_pre", id_pc, 32'h4);
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("t2_hold_pc", id_pc, 32'h4);
            checkOutput("t2_hold_instr", id_instr, memData(32'h4));
            checkOutput("t2_hold_valid", {31'h0, id_valid}, 32'h1);
            checkOutput("t2_req_off", {31'h0, imem_req}, 32'h0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t2_skid_pc", id_pc, 32'h8);
        checkOutput("t2_skid_instr", id_instr, memData(32'h8));
        checkOutput("t2_req_on", {31'h0, imem_req}, 32'h1);
        checkOutput("t2_addr_c", imem_addr, 32'hC);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t2_pc_c", id_pc, 32'hC);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t2_pc_10", id_pc, 32'h10);
        checkOutput("t2_valid", {31'h0, id_valid}, 32'h1);

        // Three-cycle memory, redirect while the request to 0x8 is pending
        applyReset();
        memLatency = 2;
        reset = 1'b1;
        waitForAddr(32'h8, "t3_reach8");
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h100, 1'b0);
        checkOutput("t3_addr_held", imem_addr, 32'h8);
        checkOutput("t3_req_held", {31'h0, imem_req}, 32'h1);
        checkOutput("t3_flush", {31'h0, id_valid}, 32'h0);
        checkOutput("t3_rfpc", rf_pc_out, 32'h100);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t3_addr_tgt", imem_addr, 32'h100);
        checkOutput("t3_dropped", {31'h0, id_valid}, 32'h0);
        begin
            int n;
            n = 0;
            while (id_valid !== 1'b1 && n < 10) begin
                applyStimulus(1'b0, 32'h0, 1'b0);
                n++;
            end
        end
        checkOutput("t3_valid_tgt", {31'h0, id_valid}, 32'h1);
        checkOutput("t3_idpc_tgt", id_pc, 32'h100);
        checkOutput("t3_instr_tgt", id_instr, memData(32'h100));

        // Redirect in the same cycle as the ack for 0xC
        applyReset();
        memLatency = 0;
        reset = 1'b1;
        waitForAddr(32'hC, "t4_reachC");
        checkOutput("t4_pre_pc", id_pc, 32'h8);
        applyStimulus(1'b1, 32'h40, 1'b0);
        checkOutput("t4_flush", {31'h0, id_valid}, 32'h0);
        checkOutput("t4_addr", imem_addr, 32'h40);
        checkOutput("t4_rfpc", rf_pc_out, 32'h40);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t4_idpc", id_pc, 32'h40);
        checkOutput("t4_valid", {31'h0, id_valid}, 32'h1);

        // Reset during an outstanding request, stray ack just after
        applyReset();
        memLatency = 2;
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t5_outstanding", {31'h0, imem_req}, 32'h1);
        reset   = 1'b0;
        memMode = 1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t5_req_drop", {31'h0, imem_req}, 32'h0);
        checkOutput("t5_rfpc", rf_pc_out, 32'h0);
        reset   = 1'b1;
        memMode = 2;
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t5_stray_valid", {31'h0, id_valid}, 32'h0);
        checkOutput("t5_restart_req", {31'h0, imem_req}, 32'h1);
        checkOutput("t5_restart_addr", imem_addr, 32'h0);
        memMode    = 0;
        memLatency = 0;
        memWait    = 0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t5_first_pc", id_pc, 32'h0);
        checkOutput("t5_first_instr", id_instr, memData(32'h0));

        // PC wrap from the top of the address space
        applyReset();
        memLatency = 0;
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0);
        checkOutput("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        checkOutput("t6_rfpc_top", rf_pc_out, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t6_rfpc_wrap", rf_pc_out, 32'h0);
        checkOutput("t6_addr_wrap", imem_addr, 32'h0);
        checkOutput("t6_idpc", id_pc, 32'hFFFF_FFFC);
        checkOutput("t6_instr", id_instr, memData(32'hFFFF_FFFC));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, failCount);
        $finish;
    end

endmodule
